// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and wait-state limits.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WAIT_MIN = 0;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  function automatic logic wait_legal(input int cycles);
    return (cycles >= WAIT_MIN) && (cycles <= WAIT_MAX);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous write, registered read, asynchronous debug read.
module dmem_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

  assign debug_data = mem[debug_addr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage slave: captures a request, stalls for WAIT_CYCLES+1 cycles, returns read data
// (pre-write word for writes) in the first non-stalled cycle, then commits any write.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_dout,
  output logic [31:0]           mem_din,
  output logic                  mem_stall,
  output logic                  mem_err,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data
);

  localparam logic [CNT_W-1:0] WAIT_INIT = WAIT_CYCLES[CNT_W-1:0];
  localparam bit               HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam bit               CFG_OK    = wait_legal(WAIT_CYCLES);

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] cap_idx;
  logic [31:0]           cap_data;
  logic                  cap_wr;

  logic                  req;
  logic                  misaligned;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] idx;

  logic                  ram_re;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_rdata;

  // Upper byte-address bits alias; folded here so they are visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], CFG_OK};

  assign req        = mem_ren | mem_wen;
  assign misaligned = |mem_addr[1:0];
  assign idx        = mem_addr[ADDR_WIDTH+1:2];
  assign accept     = (state == IDLE) & req & ~misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = HAS_WAIT ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (!req) begin
          next_state = IDLE;
        end else if (cnt == 1) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      cap_idx  <= '0;
      cap_data <= '0;
      cap_wr   <= 1'b0;
    end else if (accept) begin
      cnt      <= WAIT_INIT;
      cap_idx  <= idx;
      cap_data <= mem_dout;
      cap_wr   <= mem_wen;
    end else if ((state == BUSY) && (cnt != 0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // With zero wait states the read launches from IDLE before capture lands, so it uses the live index.
  always_comb begin
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    mem_din   = '0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cap_idx;
    if (!rst) begin
      mem_err   = req & misaligned;
      mem_stall = req & ~misaligned & (state != DONE);
      if (state == DONE) begin
        mem_din = ram_rdata;
      end
      ram_re = (next_state == DONE) && (state != DONE);
      ram_we = (state == DONE) && cap_wr;
      if (state == IDLE) begin
        ram_addr = idx;
      end
    end
  end

  dmem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .re        (ram_re),
    .we        (ram_we),
    .addr      (ram_addr),
    .wdata     (cap_data),
    .rdata     (ram_rdata),
    .debug_addr(debug_addr),
    .debug_data(debug_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table with scoreboard queue, plus flush, reset, repeat and zero-wait sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] dout = '0;
  logic [9:0]  debug_addr = '0;

  logic        ren_a, wen_a, ren_b, wen_b;
  logic [31:0] din_a, din_b, dbg_a, dbg_b;
  logic        stall_a, stall_b, err_a, err_b;
  logic [31:0] din, dbg;
  logic        stall, err;

  always #5 clk = ~clk;

  assign ren_a = ren & ~sel;
  assign wen_a = wen & ~sel;
  assign ren_b = ren & sel;
  assign wen_b = wen & sel;
  assign din   = sel ? din_b   : din_a;
  assign dbg   = sel ? dbg_b   : dbg_a;
  assign stall = sel ? stall_b : stall_a;
  assign err   = sel ? err_b   : err_a;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .mem_ren(ren_a), .mem_wen(wen_a), .mem_addr(addr), .mem_dout(dout),
    .mem_din(din_a), .mem_stall(stall_a), .mem_err(err_a), .debug_addr(debug_addr), .debug_data(dbg_a)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .mem_ren(ren_b), .mem_wen(wen_b), .mem_addr(addr), .mem_dout(dout),
    .mem_din(din_b), .mem_stall(stall_b), .mem_err(err_b), .debug_addr(debug_addr), .debug_data(dbg_b)
  );

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    int          stalls;
    logic        chk_din;
    logic [31:0] din;
    logic        err;
  } vec_t;

  typedef struct {
    int          stalls;
    logic        chk_din;
    logic [31:0] din;
    logic        err;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                              input int s, input logic c, input logic [31:0] e, input logic er);
    vec_t v;
    v.w = w; v.r = r; v.a = a; v.d = d; v.stalls = s; v.chk_din = c; v.din = e; v.err = er;
    return v;
  endfunction

  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] din_o, output logic err_o,
                        output logic [31:0] din_after);
    bit done;
    done   = 1'b0;
    stalls = 0;
    din_o  = '0;
    err_o  = 1'b0;
    @(posedge clk); #1;
    wen = w; ren = r; addr = a; dout = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
      end else begin
        din_o = din;
        err_o = err;
        done  = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL access_timeout addr=%h stalls=%0d required<40", a, stalls);
    end
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0;
    @(negedge clk);
    din_after = din;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    exp_t        e;
    int          s;
    logic [31:0] d_o, d_after;
    logic        e_o;
    e.stalls = v.stalls; e.chk_din = v.chk_din; e.din = v.din; e.err = v.err;
    sb.push_back(e);
    access(v.w, v.r, v.a, v.d, s, d_o, e_o, d_after);
    e = sb.pop_front();
    chk({tag, "_stalls"}, s, e.stalls);
    chk({tag, "_err"}, {31'd0, e_o}, {31'd0, e.err});
    if (e.chk_din) chk({tag, "_din"}, d_o, e.din);
    chk({tag, "_din_after"}, d_after, 32'd0);
  endtask

  initial begin
    logic [7:0] pat;

    #1 rst = 1'b1;
    #2;
    chk("rst_stall_a", {31'd0, stall_a}, 32'd0);
    chk("rst_err_a",   {31'd0, err_a},   32'd0);
    chk("rst_din_a",   din_a, 32'd0);
    chk("rst_din_b",   din_b, 32'd0);
    ren = 1'b1; addr = 32'h10; #1;
    chk("rst_forces_stall_low", {31'd0, stall_a}, 32'd0);
    addr = 32'h13; #1;
    chk("rst_forces_err_low", {31'd0, err_a}, 32'd0);
    ren = 1'b0; addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vecs[0]  = mk(1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 3, 0, 32'h0,         0);
    vecs[1]  = mk(0, 1, 32'h0000_0010, 32'h0,         3, 1, 32'hDEAD_BEEF, 0);
    vecs[2]  = mk(0, 1, 32'h0000_0013, 32'h0,         0, 1, 32'h0,         1);
    vecs[3]  = mk(1, 0, 32'h0000_0010, 32'hCAFE_F00D, 3, 1, 32'hDEAD_BEEF, 0);
    vecs[4]  = mk(0, 1, 32'h0000_0010, 32'h0,         3, 1, 32'hCAFE_F00D, 0);
    vecs[5]  = mk(1, 0, 32'h0000_0020, 32'h1111_1111, 3, 0, 32'h0,         0);
    vecs[6]  = mk(1, 0, 32'h0000_0040, 32'h0000_00BB, 3, 0, 32'h0,         0);
    vecs[7]  = mk(0, 1, 32'h0000_1010, 32'h0,         3, 1, 32'hCAFE_F00D, 0);
    vecs[8]  = mk(1, 1, 32'h0000_0020, 32'h2222_2222, 3, 1, 32'h1111_1111, 0);
    vecs[9]  = mk(0, 1, 32'h0000_0020, 32'h0,         3, 1, 32'h2222_2222, 0);
    vecs[10] = mk(1, 0, 32'h0000_0022, 32'h9999_9999, 0, 1, 32'h0,         1);
    vecs[11] = mk(0, 1, 32'h0000_0020, 32'h0,         3, 1, 32'h2222_2222, 0);

    sel = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    debug_addr = 10'd4;  #1; chk("dbg_idx4",  dbg, 32'hCAFE_F00D);
    debug_addr = 10'd8;  #1; chk("dbg_idx8",  dbg, 32'h2222_2222);
    debug_addr = 10'd16; #1; chk("dbg_idx16", dbg, 32'h0000_00BB);

    // Flush: drop the write after one BUSY cycle.
    @(posedge clk); #1;
    wen = 1'b1; addr = 32'h20; dout = 32'h1234_5678;
    @(negedge clk); chk("flush_accept_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("flush_busy_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    wen = 1'b0;
    #1; chk("flush_drop_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); chk("flush_din", din, 32'd0);
    run_vec("flush_read", mk(0, 1, 32'h20, 32'h0, 3, 1, 32'h2222_2222, 0));
    debug_addr = 10'd8; #1; chk("flush_dbg_idx8", dbg, 32'h2222_2222);

    // Reset asserted while the write is BUSY.
    @(posedge clk); #1;
    wen = 1'b1; addr = 32'h40; dout = 32'h0000_00AA;
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rstbusy_stall", {31'd0, stall}, 32'd0);
    chk("rstbusy_din",   din, 32'd0);
    chk("rstbusy_err",   {31'd0, err}, 32'd0);
    wen = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_vec("rstbusy_read", mk(0, 1, 32'h40, 32'h0, 3, 1, 32'h0000_00BB, 0));
    debug_addr = 10'd16; #1; chk("rstbusy_dbg_idx16", dbg, 32'h0000_00BB);

    // Held read is served repeatedly: stall pattern 1,1,1,0 twice.
    pat = 8'b1110_1110;
    @(posedge clk); #1;
    ren = 1'b1; addr = 32'h10;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("repeat_stall_%0d", k), {31'd0, stall}, {31'd0, pat[7-k]});
      if (!pat[7-k]) chk($sformatf("repeat_din_%0d", k), din, 32'hCAFE_F00D);
    end
    @(posedge clk); #1;
    ren = 1'b0;

    // Zero wait states, back-to-back write then read through an aliased address.
    sel = 1'b1;
    @(posedge clk); #1;
    wen = 1'b1; addr = 32'h0000_1040; dout = 32'h0000_0001;
    @(negedge clk); chk("b_wr_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("b_wr_done_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b1; addr = 32'h0000_0040;
    @(negedge clk); chk("b_rd_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_rd_done_stall", {31'd0, stall}, 32'd0);
    chk("b_rd_din", din, 32'h0000_0001);
    @(posedge clk); #1;
    ren = 1'b0;
    @(negedge clk); chk("b_din_after", din, 32'd0);
    debug_addr = 10'd16; #1; chk("b_dbg_idx16", dbg, 32'h0000_0001);
    run_vec("b_read_alias", mk(0, 1, 32'h0000_1040, 32'h0, 1, 1, 32'h0000_0001, 0));
    sel = 1'b0; #1;
    chk("a_dbg_idx16_isolated", dbg, 32'h0000_00BB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the pipeline's MEM-stage port (mem_ren, mem_wen, mem_addr, mem_dout in; mem_din out).
- Holds a word-addressed synchronous RAM and inserts a programmable number of wait states.
- Requests the MEM-stage stall through mem_stall until each access completes.
- Sits between the datapath and the board-level memory/debug logic.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth is 2^ADDR_WIDTH words.
WAIT_CYCLES, 2, extra busy cycles per access (0..15).

Ports:
clk  input  1  main clock, rising-edge
rst  input  1  asynchronous, active-high reset
mem_ren  input  1  read request from MEM stage
mem_wen  input  1  write request from MEM stage
mem_addr  input  32  byte address
mem_dout  input  32  write data from datapath
mem_din  output  32  read data to datapath
mem_stall  output  1  access in progress; controller must hold the MEM stage
mem_err  output  1  misaligned request flag
debug_addr  input  ADDR_WIDTH  debug word index
debug_data  output  32  RAM word at debug_addr, combinational

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Definitions:
  - req = mem_ren | mem_wen.
  - Index = mem_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias.
  - mem_wen has priority when both enables are high. The access is a write, and mem_din returns the pre-write word.
- Misaligned request (mem_addr[1:0] != 0):
  - mem_err = req & misaligned, combinational.
  - No RAM access, no stall, mem_din = 0, FSM stays in IDLE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, valid req: capture index, write data and write flag. Load cnt = WAIT_CYCLES. Go to BUSY if WAIT_CYCLES > 0, else DONE.
  - BUSY: cnt decrements each cycle. When cnt == 1, go to DONE.
  - BUSY with req dropped (pipeline flush): return to IDLE; no write is performed.
  - Entering DONE: the RAM read of the captured index is registered into rdata.
  - DONE: mem_din = rdata. If the captured flag is write, the RAM word is written with the captured data at the clock edge leaving DONE. Always DONE -> IDLE.
- Captured address and data are used during the access. Input changes while BUSY are ignored, except req dropping.
- mem_stall = req & ~misaligned & (state != DONE). It is combinational, so it is high in the accepting IDLE cycle. Total stall = WAIT_CYCLES+1 cycles; read data is valid in the first non-stalled cycle.
- mem_din = 0 whenever state != DONE.
- Repeated identical request after DONE (pipeline held by another stall) is served again. The access is idempotent.
- Back-to-back: a new request in the cycle after DONE is accepted normally. A read of a word written in the preceding DONE returns the new value.
- Reset values:
  - State IDLE, cnt 0, rdata 0.
  - mem_din 0, mem_err 0, mem_stall 0 (forced low while rst high).
  - Captured registers 0.
  - RAM contents are not reset.
- Reset mid-access: an aborted write is not performed; the FSM returns to IDLE immediately.
- debug_data reflects the RAM asynchronously and is unaffected by the FSM.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the WAIT_CYCLES legal range constant.
- Sub-module dmem_ram: single-port synchronous-write RAM with registered read and an asynchronous debug read port. The responder holds the FSM, counter, capture registers and output muxing.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010 (WAIT_CYCLES=2) -> mem_stall high exactly 3 cycles then low one cycle. debug_data at index 4 = 0xDEADBEEF afterwards.
- Read 0x0000_0010 -> stall 3 cycles, then mem_din = 0xDEADBEEF for one cycle, 0 after.
- Read 0x0000_0013 -> mem_err = 1, mem_stall = 0, mem_din = 0. RAM unchanged.
- Write 0x12345678 to 0x20, drop mem_wen after 1 BUSY cycle -> FSM back in IDLE, mem_stall low. Index 8 keeps its prior value.
- Write 0x0000_00AA to 0x40 asserting rst during BUSY -> all outputs 0 immediately, write suppressed. A following read of 0x40 returns the old data.
- WAIT_CYCLES=0: write 0x1 then read same address back-to-back -> each stalls 1 cycle, read returns 0x00000001. Address 0x0000_1040 aliases index 16 with ADDR_WIDTH=10.
